// File: rtl/mem_stage_sram.sv
// Memory stage with a multi-cycle access engine for an external 16-bit SRAM.
// Each 32-bit LDR/STR is split into a low and a high half-word access. Each
// half is held for WAIT_CYCLES+1 cycles. The pipeline is frozen until the
// access reaches DONE.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap word-misaligned
// accesses instead of performing them.
module mem_stage_sram #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MEM_BASE    = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_en,
  input  logic [3:0]  dest,
  input  logic [31:0] alu,
  input  logic [31:0] val_rm,
  output logic        wb_en_out,
  output logic        mem_read_out,
  output logic [3:0]  dest_out,
  output logic [31:0] alu_out,
  output logic [31:0] mem_data,
  output logic        freeze,
  output logic        misalign_err,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [2:0]  CNT_LAST = 3'(WAIT_CYCLES);
  localparam logic [18:0] BASE_LO  = MEM_BASE[18:0];

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        w_req, w_is_wr, w_is_rd, w_misalign;
  logic [18:0] w_off;
  logic [16:0] w_wa;
  logic [1:0]  w_unused_off;

  assign w_req   = mem_read | mem_write;
  assign w_is_wr = mem_write;
  assign w_is_rd = mem_read & ~mem_write;

  // Only the low 19 bits of the byte offset reach the 18-bit half-word address.
  assign w_off        = alu[18:0] - BASE_LO;
  assign w_wa         = w_off[18:2];
  assign w_unused_off = w_off[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_misalign   = (alu[1:0] != 2'b00);
  assign misalign_err = r_misalign;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign freeze       = w_req & (r_state != S_DONE);
  assign wb_en_out    = wb_en & ~freeze & ~misalign_err;
  assign mem_read_out = mem_read & ~freeze;
  assign dest_out     = dest;
  assign alu_out      = alu;

  // Access FSM state and hold counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: each half is held until the counter reaches WAIT_CYCLES.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = 3'd0;
        if (w_req) w_state_nxt = w_misalign ? S_DONE : S_LO;
      end
      S_LO: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HI;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_HI: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // SRAM pins are registered from the upcoming state. This lets them line up
  // with the cycle they belong to. we_n rises on the last cycle of each half
  // to commit the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (w_state_nxt)
        S_LO: begin
          sram_addr   <= {w_wa, 1'b0};
          sram_dq_out <= val_rm[15:0];
          sram_dq_oe  <= w_is_wr;
          sram_we_n   <= ~(w_is_wr && (w_cnt_nxt != CNT_LAST));
        end
        S_HI: begin
          sram_addr   <= {w_wa, 1'b1};
          sram_dq_out <= val_rm[31:16];
          sram_dq_oe  <= w_is_wr;
          sram_we_n   <= ~(w_is_wr && (w_cnt_nxt != CNT_LAST));
        end
        default: begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
        end
      endcase
    end
  end

  // Load data is captured on the last cycle of each half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_data <= 32'd0;
    end else if (w_is_rd && (r_cnt == CNT_LAST)) begin
      if (r_state == S_LO) mem_data[15:0]  <= sram_dq_in;
      if (r_state == S_HI) mem_data[31:16] <= sram_dq_in;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Trap flag is set only when IDLE jumps straight to DONE, so it lasts one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= (r_state == S_IDLE) && (w_state_nxt == S_DONE);
  end
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram (WAIT_CYCLES = 1, MEM_BASE = 1024) with a
// behavioural asynchronous SRAM that commits on the rising edge of we_n.
module tb_mem_stage_sram;

  logic        clk, rst;
  logic        mem_read, mem_write, wb_en;
  logic [3:0]  dest;
  logic [31:0] alu, val_rm;
  logic        wb_en_out, mem_read_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_out, mem_data;
  logic        freeze, misalign_err;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  int n_vec = 0;
  int n_err = 0;
  int n_fall = 0;
  logic [31:0] md_model;
  logic [15:0] sram_mem [0:63];

  mem_stage_sram #(.WAIT_CYCLES(1), .MEM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en),
    .dest(dest), .alu(alu), .val_rm(val_rm),
    .wb_en_out(wb_en_out), .mem_read_out(mem_read_out),
    .dest_out(dest_out), .alu_out(alu_out), .mem_data(mem_data),
    .freeze(freeze), .misalign_err(misalign_err),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq_in = sram_mem[sram_addr[5:0]];

  always @(posedge sram_we_n) if (!rst) sram_mem[sram_addr[5:0]] <= sram_dq_out;
  always @(negedge sram_we_n) n_fall <= n_fall + 1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one access from its IDLE cycle (c0) through DONE (c5). Inputs are
  // already driven. The expected pin activity comes from a per-cycle table.
  task automatic run_op(input string tag, input logic wr, input logic [17:0] a_prev,
                        input logic [17:0] a_lo, input logic [31:0] data);
    logic [17:0] e_addr;
    logic        e_we_n, e_oe;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      e_addr = (c == 0) ? a_prev : (c < 3) ? a_lo : a_lo + 18'd1;
      e_we_n = !(wr && (c == 1 || c == 3));
      e_oe   = wr && (c >= 1) && (c <= 4);
      chk_eq($sformatf("%s c%0d freeze", tag, c), {31'd0, freeze}, {31'd0, c < 5});
      chk_eq($sformatf("%s c%0d addr", tag, c), {14'd0, sram_addr}, {14'd0, e_addr});
      chk_eq($sformatf("%s c%0d we_n", tag, c), {31'd0, sram_we_n}, {31'd0, e_we_n});
      chk_eq($sformatf("%s c%0d oe", tag, c), {31'd0, sram_dq_oe}, {31'd0, e_oe});
      chk_eq($sformatf("%s c%0d rd_out", tag, c), {31'd0, mem_read_out},
             {31'd0, !wr && (c == 5)});
      chk_eq($sformatf("%s c%0d wb_out", tag, c), {31'd0, wb_en_out},
             {31'd0, wb_en && (c == 5)});
      chk_eq($sformatf("%s c%0d mis", tag, c), {31'd0, misalign_err}, 32'd0);
      if (wr && (c == 1 || c == 2))
        chk_eq($sformatf("%s c%0d dq_lo", tag, c), {16'd0, sram_dq_out}, {16'd0, data[15:0]});
      if (wr && (c == 3 || c == 4))
        chk_eq($sformatf("%s c%0d dq_hi", tag, c), {16'd0, sram_dq_out}, {16'd0, data[31:16]});
      if (!wr && c == 3)
        chk_eq($sformatf("%s lo_half", tag), {16'd0, mem_data[15:0]}, {16'd0, data[15:0]});
    end
    if (!wr) md_model = data;
    chk_eq($sformatf("%s mem_data", tag), mem_data, md_model);
  endtask

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; wb_en = 0; dest = 0; alu = 0; val_rm = 0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    md_model = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst freeze", {31'd0, freeze}, 32'd0);
    chk_eq("rst mem_data", mem_data, 32'd0);
    chk_eq("rst we_n", {31'd0, sram_we_n}, 32'd1);
    chk_eq("rst oe", {31'd0, sram_dq_oe}, 32'd0);
    chk_eq("rst addr", {14'd0, sram_addr}, 32'd0);
    chk_eq("rst dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk_eq("rst mis", {31'd0, misalign_err}, 32'd0);
    rst = 1'b0;

    // Store 0xCAFE1234 at 1024 -> half-words 0,1.
    @(posedge clk); #1;
    mem_write = 1; alu = 32'd1024; val_rm = 32'hCAFE_1234;
    run_op("wr1024", 1'b1, 18'd0, 18'd0, 32'hCAFE_1234);
    chk_eq("wr1024 falls", n_fall, 32'd2);
    chk_eq("wr1024 sram lo", {16'd0, sram_mem[0]}, 32'h0000_1234);
    chk_eq("wr1024 sram hi", {16'd0, sram_mem[1]}, 32'h0000_CAFE);

    // Non-memory instruction: everything passes through in the same cycle.
    @(posedge clk); #1;
    clear_inputs();
    wb_en = 1; dest = 4'd3; alu = 32'd5;
    #1;
    chk_eq("add freeze", {31'd0, freeze}, 32'd0);
    chk_eq("add wb_out", {31'd0, wb_en_out}, 32'd1);
    chk_eq("add dest", {28'd0, dest_out}, 32'd3);
    chk_eq("add alu", alu_out, 32'd5);
    @(negedge clk);
    chk_eq("add we_n", {31'd0, sram_we_n}, 32'd1);
    chk_eq("add addr held", {14'd0, sram_addr}, 32'd1);

    // Load back from 1024.
    @(posedge clk); #1;
    clear_inputs();
    mem_read = 1; wb_en = 1; dest = 4'd5; alu = 32'd1024;
    run_op("rd1024", 1'b0, 18'd1, 18'd0, 32'hCAFE_1234);

    // Fill words at 1028 and 1032 for the back-to-back loads.
    @(posedge clk); #1;
    clear_inputs();
    mem_write = 1; alu = 32'd1028; val_rm = 32'hBBBB_AAAA;
    run_op("wr1028", 1'b1, 18'd1, 18'd2, 32'hBBBB_AAAA);
    @(posedge clk); #1;
    alu = 32'd1032; val_rm = 32'h6666_5555;
    run_op("wr1032", 1'b1, 18'd3, 18'd4, 32'h6666_5555);
    chk_eq("fill falls", n_fall, 32'd6);

    // Back-to-back loads: one IDLE cycle with freeze high between them.
    @(posedge clk); #1;
    clear_inputs();
    mem_read = 1; alu = 32'd1028;
    run_op("rd1028", 1'b0, 18'd5, 18'd2, 32'hBBBB_AAAA);
    @(posedge clk); #1;
    alu = 32'd1032;
    run_op("rd1032", 1'b0, 18'd3, 18'd4, 32'h6666_5555);

    // Reset in the middle of the high half of a store.
    @(posedge clk); #1;
    clear_inputs();
    mem_write = 1; alu = 32'd1036; val_rm = 32'h7777_8888;
    repeat (4) @(negedge clk);
    chk_eq("midrst pre we_n", {31'd0, sram_we_n}, 32'd0);
    chk_eq("midrst pre addr", {14'd0, sram_addr}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("midrst we_n", {31'd0, sram_we_n}, 32'd1);
    chk_eq("midrst oe", {31'd0, sram_dq_oe}, 32'd0);
    chk_eq("midrst mem_data", mem_data, 32'd0);
    chk_eq("midrst addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b0;
    md_model = 32'd0;
    // A full-length access right after reset shows the FSM restarted from IDLE.
    @(posedge clk); #1;
    mem_read = 1; alu = 32'd1024;
    run_op("post_rst rd", 1'b0, 18'd0, 18'd0, 32'hCAFE_1234);

    // Misaligned load at 1026.
    @(posedge clk); #1;
    clear_inputs();
    mem_read = 1; wb_en = 1; alu = 32'd1026;
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    chk_eq("mis c0 freeze", {31'd0, freeze}, 32'd1);
    chk_eq("mis c0 err", {31'd0, misalign_err}, 32'd0);
    @(negedge clk);
    chk_eq("mis c1 freeze", {31'd0, freeze}, 32'd0);
    chk_eq("mis c1 err", {31'd0, misalign_err}, 32'd1);
    chk_eq("mis c1 wb_out", {31'd0, wb_en_out}, 32'd0);
    chk_eq("mis c1 we_n", {31'd0, sram_we_n}, 32'd1);
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    chk_eq("mis c2 err", {31'd0, misalign_err}, 32'd0);
`else
    run_op("mis rd", 1'b0, 18'd1, 18'd0, 32'hCAFE_1234);
`endif
    chk_eq("final falls", n_fall, 32'd8);

    @(posedge clk); #1;
    clear_inputs();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
# mem_stage_sram

Memory stage of the 5-stage pipeline, between the EXE stage register and the MEM stage register. It executes LDR/STR against an external 16-bit SRAM using a multi-cycle access state machine. While an access is in progress it asserts `freeze` to stall the pipeline. It passes `wb_en`, `mem_read`, `dest` and the ALU result through to the MEM stage register, together with the 32-bit load data.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra hold cycles per 16-bit half-access; legal range 1..7.
- `MEM_BASE`, default 32'd1024: byte address mapped to SRAM word 0.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `mem_read`, in, 1: load request from the EXE stage register.
- `mem_write`, in, 1: store request from the EXE stage register.
- `wb_en`, in, 1: writeback enable from EXE.
- `dest`, in, 4: destination register.
- `alu`, in, 32: ALU result; the byte address for memory ops.
- `val_rm`, in, 32: store data.
- `wb_en_out`, out, 1: to MEM stage register; `wb_en & ~freeze`.
- `mem_read_out`, out, 1: to MEM stage register; `mem_read & ~freeze`.
- `dest_out`, out, 4: `dest`, passed through combinationally.
- `alu_out`, out, 32: `alu`, passed through combinationally.
- `mem_data`, out, 32: registered load result.
- `freeze`, out, 1: pipeline stall request.
- `misalign_err`, out, 1: misaligned-access flag (see Configuration).
- `sram_addr`, out, 18: SRAM half-word address.
- `sram_dq_out`, out, 16: write data to SRAM.
- `sram_dq_oe`, out, 1: SRAM data bus output enable.
- `sram_dq_in`, in, 16: read data from SRAM.
- `sram_we_n`, out, 1: SRAM write strobe, active-low.

## Operation
- `req = mem_read | mem_write`. If both are high, write takes priority.
- Word address: `wa = (alu - MEM_BASE) >> 2`. Low half is at `sram_addr = {wa[16:0],1'b0}`, high half at `{wa[16:0],1'b1}`. Address arithmetic is 32-bit unsigned; wrap-around is not checked.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE → LO when `req`.
  - LO → HI after `WAIT_CYCLES+1` cycles, counted by a hold counter (`cnt`).
  - HI → DONE after `WAIT_CYCLES+1` cycles.
  - DONE → IDLE unconditionally.
- `freeze = req & (state != DONE)`, combinational.
  - In IDLE with `req` high, `freeze` is high in the same cycle.
- Reads:
  - `sram_we_n = 1`, `sram_dq_oe = 0`.
  - `sram_dq_in` is sampled into `mem_data[15:0]` on the last LO cycle and into `mem_data[31:16]` on the last HI cycle.
- Writes:
  - `sram_dq_oe = 1` throughout LO and HI.
  - `sram_dq_out` is `val_rm[15:0]` in LO and `val_rm[31:16]` in HI.
  - `sram_we_n = 0` on every LO/HI cycle except the last cycle of each half. The rising edge of `we_n` commits the half.
  - `mem_data` is unchanged by writes.
- `sram_addr`, `sram_dq_out`, `sram_we_n` and `sram_dq_oe` are registered outputs. In IDLE and DONE they take their idle values: `we_n = 1`, `oe = 0`, address held.
- Non-memory instructions: `freeze = 0`, the FSM stays in IDLE, and all pass-through outputs are live.

## Timing
- Reset values:
  - FSM state IDLE, `cnt = 0`.
  - `mem_data = 0`, `sram_addr = 0`, `sram_dq_out = 0`, `sram_dq_oe = 0`, `sram_we_n = 1`, `misalign_err = 0`.
  - Combinational outputs follow their inputs.
- Access latency: `freeze` is high for `1 + 2*(WAIT_CYCLES+1)` cycles (the IDLE cycle, LO, HI).
  - `freeze` goes low in DONE.
  - `mem_data` is valid in DONE, and the MEM stage register captures it on the edge that leaves DONE.
- Back-to-back memory ops: after DONE the FSM spends one IDLE cycle, then re-enters LO. There is no DONE→LO shortcut.
- Reset mid-access: the FSM returns to IDLE and `sram_we_n` rises immediately (asynchronously), so a partial write leaves the half-word in flight undefined. `mem_data` clears to 0.
- Inputs must be stable while `freeze` is high; upstream holds them.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A `req` with `alu[1:0] != 0` skips the SRAM access; the FSM goes IDLE → DONE.
  - `freeze` is high for one cycle (the IDLE cycle).
  - `misalign_err` is high in DONE for exactly one cycle, and `wb_en_out` is forced to 0 in that cycle.
  - `sram_we_n` never falls during a trapped access.
- `MEM_MISALIGN_TRAP_EN` undefined:
  - `alu[1:0]` is ignored and the access proceeds at `wa`.
  - `misalign_err` is tied to 0.

## Test plan
- Reset, then `mem_write` with `alu = 1024`, `val_rm = 32'hCAFE_1234`, `WAIT_CYCLES = 1` → `freeze` high 5 cycles; `sram_addr` 0 then 1; `dq_out` 16'h1234 then 16'hCAFE; one `we_n` low pulse per half.
- `mem_read`, `alu = 1024`, `sram_dq_in` modelling the prior write → `mem_data = 32'hCAFE_1234` in DONE; `mem_read_out = 1` only in DONE.
- ADD with `wb_en = 1`, `dest = 4'd3`, `alu = 5` → `freeze = 0`, `wb_en_out = 1`, `dest_out = 3`, `alu_out = 5` in the same cycle.
- Two consecutive loads at 1028 and 1032 → `sram_addr` sequences 2,3 then 4,5, with one IDLE cycle between; each `mem_data` is correct.
- `rst` asserted during write phase HI → `sram_we_n = 1` and `sram_dq_oe = 0` immediately; state IDLE; `mem_data = 0`.
- `MEM_MISALIGN_TRAP_EN` defined, load at `alu = 1026` → no `we_n` activity, `freeze` high 1 cycle, `misalign_err` pulses 1 cycle, `wb_en_out = 0`.
